div_sequencer: RTL

//  Multi-cycle restoring-division controller for the RISC divider datapath. It is the driving end of the ALU

---
 rtl/div_pkg.sv | 15 +
 rtl/div_sign_fix.sv | 37 +++
 rtl/div_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the restoring-division sequencer: ALU select codes and FSM state encoding.
package div_pkg;

  localparam logic [4:0] ALU_PASS = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00101;
  localparam logic [4:0] ALU_SHL  = 5'b10100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational operand magnitude conversion and result sign restoration for signed division.
// Only instantiated by div_sequencer when SIGNED_DIV_EN is defined.
module div_sign_fix #(
  parameter int BITS = 32
) (
  input  logic                   signed_op,
  input  logic signed [BITS-1:0] dividend,
  input  logic signed [BITS-1:0] divisor,
  output logic        [BITS-1:0] dividend_mag,
  output logic        [BITS-1:0] divisor_mag,
  output logic                   neg_q,
  output logic                   neg_r,
  input  logic                   fix_neg_q,
  input  logic                   fix_neg_r,
  input  logic        [BITS-1:0] quotient_mag,
  input  logic        [BITS-1:0] remainder_mag,
  output logic        [BITS-1:0] quotient_fix,
  output logic        [BITS-1:0] remainder_fix
);

  logic dividend_neg;
  logic divisor_neg;

  assign dividend_neg = signed_op & dividend[BITS-1];
  assign divisor_neg  = signed_op & divisor[BITS-1];

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign dividend_mag = dividend_neg ? BITS'(-dividend) : BITS'(dividend);
  assign divisor_mag  = divisor_neg  ? BITS'(-divisor)  : BITS'(divisor);

  assign neg_q = dividend_neg ^ divisor_neg;
  assign neg_r = dividend_neg;

  assign quotient_fix  = fix_neg_q ? BITS'(-quotient_mag)  : quotient_mag;
  assign remainder_fix = fix_neg_r ? BITS'(-remainder_mag) : remainder_mag;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring-division controller driving an external ALU (shift step, then subtract step per bit).
// Optional signed division is built in when the macro SIGNED_DIV_EN is defined.
module div_sequencer
  import div_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signed_op,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            dbz,
  output logic            seq_err,
  output logic [4:0]      alu_select,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  input  logic [BITS-1:0] alu_out,
  input  logic            alu_cout,
  input  logic            alu_shift,
  input  logic            alu_lr
);

  localparam int CW = $clog2(BITS + 1);

  state_t            state;
  state_t            state_nxt;
  logic [BITS-1:0]   d_reg;
  logic [2*BITS-1:0] rq;
  logic [CW-1:0]     cnt;

  logic [BITS-1:0]   r_cur;
  logic [BITS-1:0]   r_nxt;
  logic [BITS-1:0]   q_nxt;
  logic [BITS-1:0]   q_final;
  logic [BITS-1:0]   r_final;
  logic [BITS-1:0]   dividend_mag;
  logic [BITS-1:0]   divisor_mag;
  logic              accept;
  logic              last_step;

  assign r_cur     = rq[2*BITS-1:BITS];
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SUB) && (cnt == CW'(BITS - 1));

  // Result of the current subtract step: restore on borrow, otherwise take the difference.
  assign r_nxt = alu_cout ? alu_out : r_cur;
  assign q_nxt = {rq[BITS-1:1], alu_cout};

`ifdef SIGNED_DIV_EN
  logic neg_q_in;
  logic neg_r_in;
  logic neg_q_reg;
  logic neg_r_reg;

  div_sign_fix #(
    .BITS(BITS)
  ) u_sign_fix (
    .signed_op     (signed_op),
    .dividend      (dividend),
    .divisor       (divisor),
    .dividend_mag  (dividend_mag),
    .divisor_mag   (divisor_mag),
    .neg_q         (neg_q_in),
    .neg_r         (neg_r_in),
    .fix_neg_q     (neg_q_reg),
    .fix_neg_r     (neg_r_reg),
    .quotient_mag  (q_nxt),
    .remainder_mag (r_nxt),
    .quotient_fix  (q_final),
    .remainder_fix (r_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (accept) begin
      neg_q_reg <= neg_q_in;
      neg_r_reg <= neg_r_in;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign dividend_mag     = dividend;
  assign divisor_mag      = divisor;
  assign q_final          = q_nxt;
  assign r_final          = r_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    alu_select = ALU_PASS;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        alu_select = ALU_SHL;
        alu_a      = r_cur;
        state_nxt  = SUB;
      end
      SUB: begin
        alu_select = ALU_SUB;
        alu_a      = r_cur;
        alu_b      = d_reg;
        state_nxt  = last_step ? DONE : SHIFT;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working {R,Q} register and divisor; only meaningful between accept and DONE.
  always_ff @(posedge clk) begin
    if (accept) begin
      d_reg <= divisor_mag;
      rq    <= {{BITS{1'b0}}, dividend_mag};
    end else if (state == SHIFT) begin
      rq <= rq << 1;
    end else if (state == SUB) begin
      rq <= {r_nxt, q_nxt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      dbz       <= 1'b0;
      seq_err   <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if ((state == SHIFT) && !(alu_shift && alu_lr)) begin
        seq_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            dbz  <= (divisor == '0);
            if (divisor == '0) begin
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        SUB: begin
          cnt <= cnt + 1'b1;
          if (last_step) begin
            out_valid <= 1'b1;
            quotient  <= q_final;
            remainder <= r_final;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
